// File: rtl/dm_sb_pkg.sv
// Shared types and helpers for the data-memory store buffer.
package dm_sb_pkg;

    localparam int unsigned SB_DEPTH = 4;
    localparam int unsigned SB_AW    = 32;
    localparam int unsigned SB_DW    = 32;
    localparam int unsigned SB_PCW   = 32;

    typedef struct packed {
        logic [SB_AW-1:0]  addr;
        logic [SB_DW-1:0]  data;
        logic [SB_PCW-1:0] pc;
    } sb_entry_t;

    // Word index of a byte address; the low two bits never take part in matching.
    function automatic logic [SB_AW-3:0] word_idx(input logic [SB_AW-1:0] a);
        return a[SB_AW-1:2];
    endfunction

endpackage

// File: rtl/dm_sb_fwd_match.sv
// Youngest-first address matcher used to forward buffered store data to loads.
module dm_sb_fwd_match
    import dm_sb_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH,
    localparam int unsigned PW   = $clog2(DEPTH)
) (
    input  sb_entry_t          i_entries [DEPTH],
    input  logic [DEPTH-1:0]   i_valid,
    input  logic [PW-1:0]      i_head,
    input  logic [SB_AW-1:0]   i_ld_addr,
    output logic               o_hit,
    output logic [SB_DW-1:0]   o_data
);

    logic [PW-1:0] w_idx;

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            w_idx = i_head + PW'(k);
            if (i_valid[w_idx] &&
                (word_idx(i_entries[w_idx].addr) == word_idx(i_ld_addr))) begin
                o_hit  = 1'b1;
                o_data = i_entries[w_idx].data;
            end
        end
    end

endmodule

// File: rtl/dm_store_buffer.sv
// In-order store FIFO ahead of data memory: drains when the port is free, forwards to loads.
module dm_store_buffer
    import dm_sb_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH,
    parameter int unsigned AW    = SB_AW,
    parameter int unsigned DW    = SB_DW,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [AW-1:0] st_addr,
    input  logic [DW-1:0] st_data,
    input  logic [31:0]   st_pc,
    input  logic          ld_req,
    input  logic [AW-1:0] ld_addr,
    output logic          ld_hit,
    output logic [DW-1:0] ld_data,
    output logic          dm_we,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_wd,
    output logic [31:0]   dm_pc,
    output logic          empty,
    output logic [CW-1:0] count
);

    sb_entry_t        r_mem [DEPTH];
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [DEPTH-1:0] w_valid;
    logic [PW-1:0]    w_off;
    logic             w_hit;
    logic [SB_DW-1:0] w_fwd_data;
    sb_entry_t        w_new;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = st_valid && !w_full;
    // Loads own the single DM port; drain only on cycles without one.
    assign w_pop   = !w_empty && !ld_req;

    assign w_new.addr = SB_AW'(st_addr);
    assign w_new.data = SB_DW'(st_data);
    assign w_new.pc   = SB_PCW'(st_pc);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + PW'(1);
            if (w_pop)  r_head <= r_head + PW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
        end
    end

    // Entry payloads need no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (reset && w_push) r_mem[r_tail] <= w_new;
    end

    // An entry is live when its distance from head is below the occupancy.
    always_comb begin
        w_valid = '0;
        w_off   = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            w_off      = PW'(i) - r_head;
            w_valid[i] = ({1'b0, w_off} < r_count);
        end
    end

    dm_sb_fwd_match #(.DEPTH(DEPTH)) u_fwd (
        .i_entries (r_mem),
        .i_valid   (w_valid),
        .i_head    (r_head),
        .i_ld_addr (SB_AW'(ld_addr)),
        .o_hit     (w_hit),
        .o_data    (w_fwd_data)
    );

    assign st_ready = !w_full;
    assign ld_hit   = w_hit;
    assign ld_data  = DW'(w_fwd_data);
    assign dm_we    = w_pop;
    assign dm_addr  = AW'(r_mem[r_head].addr);
    assign dm_wd    = DW'(r_mem[r_head].data);
    assign dm_pc    = 32'(r_mem[r_head].pc);
    assign empty    = w_empty;
    assign count    = r_count;

endmodule

// File: tb/tb_dm_store_buffer.sv
// Directed self-checking bench for the data-memory store buffer.
module tb_dm_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [31:0] st_pc;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wd;
    logic [31:0] dm_pc;
    logic        empty;
    logic [2:0]  count;

    int checks   = 0;
    int failures = 0;

    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];

    always #5 clk = ~clk;

    dm_store_buffer dut (
        .clk      (clk),
        .reset    (reset),
        .st_valid (st_valid),
        .st_ready (st_ready),
        .st_addr  (st_addr),
        .st_data  (st_data),
        .st_pc    (st_pc),
        .ld_req   (ld_req),
        .ld_addr  (ld_addr),
        .ld_hit   (ld_hit),
        .ld_data  (ld_data),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wd    (dm_wd),
        .dm_pc    (dm_pc),
        .empty    (empty),
        .count    (count)
    );

    // Record every DM write the way the memory would see it.
    always @(posedge clk) begin
        if (dm_we === 1'b1) begin
            log_addr.push_back(dm_addr);
            log_data.push_back(dm_wd);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] a, input logic [31:0] d);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_pc    = 32'h0040_0000 | a;
        tick();
        st_valid = 1'b0;
    endtask

    task automatic clear_log;
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic test_reset;
        reset = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_pc = '0;
        ld_req = 1'b0; ld_addr = '0;
        tick(); tick();
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (dm_we !== 1'b0) begin failures++; $display("FAIL reset_dm_we got=%b exp=0", dm_we); end
        checks++; if (st_ready !== 1'b1) begin failures++; $display("FAIL reset_st_ready got=%b exp=1", st_ready); end
        checks++; if (ld_hit !== 1'b0 || ld_data !== 32'h0) begin failures++; $display("FAIL reset_ld got hit=%b data=%h exp 0/0", ld_hit, ld_data); end
        push_one(32'h10, 32'hAA);
        #1;
        checks++; if (empty !== 1'b1 || count !== 3'd0) begin failures++; $display("FAIL reset_push_ignored got empty=%b count=%0d", empty, count); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single;
        clear_log();
        ld_req = 1'b0;
        push_one(32'h100, 32'h1234_5678);
        #1;
        checks++; if (dm_we !== 1'b1) begin failures++; $display("FAIL single_dm_we got=%b exp=1", dm_we); end
        checks++; if (dm_addr !== 32'h100 || dm_wd !== 32'h1234_5678) begin failures++; $display("FAIL single_head got a=%h d=%h exp 100/12345678", dm_addr, dm_wd); end
        checks++; if (dm_pc !== 32'h0040_0100) begin failures++; $display("FAIL single_pc got=%h exp=00400100", dm_pc); end
        tick();
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL single_empty_after got=%b exp=1", empty); end
        checks++; if (log_addr.size() != 1) begin failures++; $display("FAIL single_writes got=%0d exp=1", log_addr.size()); end
    endtask

    task automatic test_fill_backpressure;
        clear_log();
        ld_req = 1'b1;
        for (int i = 0; i < 4; i++) push_one(32'h1000 + 32'(4*i), 32'hD0 + 32'(i));
        #1;
        checks++; if (count !== 3'd4 || st_ready !== 1'b0) begin failures++; $display("FAIL fill_full got count=%0d ready=%b exp 4/0", count, st_ready); end
        checks++; if (dm_we !== 1'b0) begin failures++; $display("FAIL fill_ld_blocks got=%b exp=0", dm_we); end
        st_valid = 1'b1; st_addr = 32'h2000; st_data = 32'hFF;
        tick(); tick();
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL fill_fifth_held got=%0d exp=4", count); end
        // Full with a pop in the same edge: the push is still refused.
        ld_req = 1'b0;
        tick();
        checks++; if (count !== 3'd3) begin failures++; $display("FAIL full_pop_no_push got=%0d exp=3", count); end
        st_valid = 1'b0;
        tick(); tick(); tick();
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL fill_drained got empty=%b", empty); end
        checks++; if (log_addr.size() != 4) begin failures++; $display("FAIL fill_write_count got=%0d exp=4", log_addr.size()); end
        for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
            checks++;
            if (log_addr[i] !== 32'h1000 + 32'(4*i) || log_data[i] !== 32'hD0 + 32'(i)) begin
                failures++; $display("FAIL fill_order[%0d] got a=%h d=%h", i, log_addr[i], log_data[i]);
            end
        end
    endtask

    task automatic test_forwarding;
        clear_log();
        ld_req = 1'b1;
        push_one(32'h200, 32'h1);
        push_one(32'h204, 32'h2);
        push_one(32'h200, 32'h3);
        ld_addr = 32'h202; #1;
        checks++; if (ld_hit !== 1'b1 || ld_data !== 32'h3) begin failures++; $display("FAIL fwd_youngest got hit=%b d=%h exp 1/3", ld_hit, ld_data); end
        ld_addr = 32'h204; #1;
        checks++; if (ld_hit !== 1'b1 || ld_data !== 32'h2) begin failures++; $display("FAIL fwd_204 got hit=%b d=%h exp 1/2", ld_hit, ld_data); end
        ld_addr = 32'h300; #1;
        checks++; if (ld_hit !== 1'b0 || ld_data !== 32'h0) begin failures++; $display("FAIL fwd_miss got hit=%b d=%h exp 0/0", ld_hit, ld_data); end
        st_valid = 1'b1; st_addr = 32'h300; st_data = 32'h9; st_pc = 32'h0; #1;
        checks++; if (ld_hit !== 1'b0) begin failures++; $display("FAIL fwd_same_cycle_push got hit=%b exp=0", ld_hit); end
        tick();
        st_valid = 1'b0; #1;
        checks++; if (ld_hit !== 1'b1 || ld_data !== 32'h9) begin failures++; $display("FAIL fwd_after_push got hit=%b d=%h exp 1/9", ld_hit, ld_data); end
        ld_req = 1'b0; ld_addr = 32'h200; #1;
        checks++; if (ld_hit !== 1'b1 || ld_data !== 32'h3) begin failures++; $display("FAIL fwd_no_ldreq got hit=%b d=%h exp 1/3", ld_hit, ld_data); end
        tick(); tick(); tick();
        ld_addr = 32'h300; #1;
        checks++; if (ld_hit !== 1'b1 || ld_data !== 32'h9 || dm_we !== 1'b1) begin failures++; $display("FAIL fwd_popping got hit=%b d=%h we=%b exp 1/9/1", ld_hit, ld_data, dm_we); end
        tick();
        checks++; if (empty !== 1'b1 || ld_hit !== 1'b0) begin failures++; $display("FAIL fwd_drained got empty=%b hit=%b", empty, ld_hit); end
    endtask

    task automatic test_back_to_back;
        clear_log();
        ld_req = 1'b1;
        push_one(32'h3000, 32'hE0);
        push_one(32'h3004, 32'hE1);
        ld_req = 1'b0;
        for (int i = 2; i < 10; i++) begin
            push_one(32'h3000 + 32'(4*i), 32'hE0 + 32'(i));
            checks++; if (count !== 3'd2) begin failures++; $display("FAIL stream_count[%0d] got=%0d exp=2", i, count); end
        end
        tick(); tick();
        checks++; if (empty !== 1'b1 || log_addr.size() != 10) begin failures++; $display("FAIL stream_done got empty=%b writes=%0d exp 1/10", empty, log_addr.size()); end
        for (int i = 0; i < 10 && i < log_addr.size(); i++) begin
            checks++;
            if (log_addr[i] !== 32'h3000 + 32'(4*i) || log_data[i] !== 32'hE0 + 32'(i)) begin
                failures++; $display("FAIL stream_order[%0d] got a=%h d=%h", i, log_addr[i], log_data[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        clear_log();
        ld_req = 1'b1;
        for (int i = 0; i < 3; i++) push_one(32'h4000 + 32'(4*i), 32'hC0 + 32'(i));
        #1;
        checks++; if (count !== 3'd3) begin failures++; $display("FAIL mid_count_before got=%0d exp=3", count); end
        reset = 1'b0;
        tick();
        reset = 1'b1; ld_req = 1'b0; #1;
        checks++; if (dm_we !== 1'b0 || count !== 3'd0 || empty !== 1'b1) begin failures++; $display("FAIL mid_reset_state got we=%b count=%0d empty=%b", dm_we, count, empty); end
        tick(); tick(); tick();
        checks++; if (log_addr.size() != 0) begin failures++; $display("FAIL mid_no_writes got=%0d exp=0", log_addr.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_backpressure();
        test_forwarding();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
